// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for serial_adder_ctrl.
// Revision: 1.0
`default_nettype none

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial add/subtract controller around one Full_Adder.
// Optional subtraction enabled by macro SERIAL_SUB_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module Full_Adder (
  input  wire a,
  input  wire b,
  input  wire cin,
  output wire sum,
  output wire cout
);
  wire ab_x;
  wire ab_a;
  wire cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (sum, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (cout, ab_a, cx_a);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_b;
  logic             fa_s;
  logic             fa_co;
  logic             cin_load;
  logic             msb_cycle;

`ifdef SERIAL_SUB_EN
  logic sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      sub_q <= bus.sub;
    end
  end

  assign fa_b     = rb[0] ^ sub_q;
  assign cin_load = bus.sub;
`else
  logic unused_sub;

  assign unused_sub = bus.sub;
  assign fa_b       = rb[0];
  assign cin_load   = 1'b0;
`endif

  Full_Adder u_fa (
    .a    (ra[0]),
    .b    (fa_b),
    .cin  (c),
    .sum  (fa_s),
    .cout (fa_co)
  );

  assign msb_cycle = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (msb_cycle) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      rs     <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ra  <= bus.a;
            rb  <= bus.b;
            c   <= cin_load;
            cnt <= '0;
          end
        end
        RUN: begin
          rs  <= {fa_s, rs[WIDTH-1:1]};
          c   <= fa_co;
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          cnt <= cnt + CW'(1);
          // During the MSB cycle c still holds the carry into the MSB.
          if (msb_cycle) begin
            sum_q  <= {fa_s, rs[WIDTH-1:1]};
            cout_q <= fa_co;
            ovf_q  <= c ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

`default_nettype wire
